// File: rtl/game_pkg.sv
// Shared definitions for the reaction-game blocks: arbiter state encoding and
// the grant-id width helper.
package game_pkg;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_WATCH = 2'd1;
    localparam logic [1:0] ARB_GRANT = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ARB_IDLE,
        WATCH = ARB_WATCH,
        GRANT = ARB_GRANT
    } arb_state_e;

    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: synchroniser, debounce counter and a one-cycle press event on the
// debounced 0 -> 1 (released -> held) transition.
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic BTN_N,
    output logic LEVEL,
    output logic PRESS_EVT
);

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [7:0]             cnt_q;
    logic                   level_q;
    logic                   prev_q;
    logic                   held_s;

    always_ff @(posedge CLK) begin
        if (RESET) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], BTN_N};
    end

    assign held_s = ~sync_q[SYNC_STAGES-1];

    // Counter runs only while the synchronised level disagrees with the
    // debounced one; any return to agreement restarts it from zero.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            prev_q <= level_q;
            if (held_s == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                level_q <= held_s;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign LEVEL     = level_q;
    assign PRESS_EVT = level_q & ~prev_q;

endmodule

// File: rtl/press_arbiter.sv
// Reaction-game button arbiter: debounces every player's button and grants the
// first qualified press of each round, round-robin among simultaneous presses.
module press_arbiter
    import game_pkg::*;
#(
    parameter int N_PLAYERS       = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int IDW            = idw(N_PLAYERS)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [N_PLAYERS-1:0] BTN_N,
    input  logic                 ARM,
    input  logic                 EARLY,
    input  logic                 LIVE,
    input  logic                 ACK,
    output logic                 GRANT_VALID,
    output logic [IDW-1:0]       GRANT_ID,
    output logic                 GRANT_FALSE,
    output logic                 BUSY,
    output logic [N_PLAYERS-1:0] PRESSED
);

    logic [N_PLAYERS-1:0] level;
    logic [N_PLAYERS-1:0] evt;

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_btn
        btn_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .CLK      (CLK),
            .RESET    (RESET),
            .BTN_N    (BTN_N[g]),
            .LEVEL    (level[g]),
            .PRESS_EVT(evt[g])
        );
    end

    arb_state_e     state_q;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           grant_valid_q, grant_false_q, busy_q;
    logic [IDW-1:0] grant_id_q;
    logic           any_evt;
    logic [IDW-1:0] pick_id;

    // Scan from the top offset down so the last hit is the one closest to
    // the pointer (wrapping), giving round-robin priority.
    always_comb begin
        int j;
        j       = 0;
        any_evt = 1'b0;
        pick_id = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            j = int'(ptr_q) + i;
            if (j >= N_PLAYERS) j = j - N_PLAYERS;
            if (evt[j]) begin
                any_evt = 1'b1;
                pick_id = IDW'(j);
            end
        end
    end

    always_comb begin
        if (int'(pick_id) == N_PLAYERS - 1) ptr_d = '0;
        else                                ptr_d = pick_id + IDW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            grant_false_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ARM) begin
                        state_q <= WATCH;
                        busy_q  <= 1'b1;
                    end
                end
                WATCH: begin
                    // Presses while neither EARLY nor LIVE are dropped.
                    if (any_evt && (EARLY || LIVE)) begin
                        state_q       <= GRANT;
                        grant_valid_q <= 1'b1;
                        grant_id_q    <= pick_id;
                        grant_false_q <= EARLY;
                        ptr_q         <= ptr_d;
                    end
                end
                GRANT: begin
                    if (ACK) begin
                        state_q       <= IDLE;
                        grant_valid_q <= 1'b0;
                        grant_id_q    <= '0;
                        grant_false_q <= 1'b0;
                        busy_q        <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    grant_valid_q <= 1'b0;
                    grant_id_q    <= '0;
                    grant_false_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign GRANT_VALID = grant_valid_q;
    assign GRANT_ID    = grant_id_q;
    assign GRANT_FALSE = grant_false_q;
    assign BUSY        = busy_q;
    assign PRESSED     = level;

endmodule

// File: tb/tb_press_arbiter.sv
// Directed bench for press_arbiter (2 players, 2 sync stages, debounce 4).
module tb_press_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [1:0] BTN_N;
    logic       ARM, EARLY, LIVE, ACK;
    logic       GRANT_VALID;
    logic [0:0] GRANT_ID;
    logic       GRANT_FALSE;
    logic       BUSY;
    logic [1:0] PRESSED;

    int n_chk  = 0;
    int n_fail = 0;

    press_arbiter #(
        .N_PLAYERS      (2),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .BTN_N      (BTN_N),
        .ARM        (ARM),
        .EARLY      (EARLY),
        .LIVE       (LIVE),
        .ACK        (ACK),
        .GRANT_VALID(GRANT_VALID),
        .GRANT_ID   (GRANT_ID),
        .GRANT_FALSE(GRANT_FALSE),
        .BUSY       (BUSY),
        .PRESSED    (PRESSED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge; the next edge samples them.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic arm();
        ARM = 1'b1;
        tick();
        ARM = 1'b0;
    endtask

    task automatic ack();
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
    endtask

    task automatic release_all();
        BTN_N = 2'b11;
        repeat (12) tick();
    endtask

    task automatic wait_grant(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (!GRANT_VALID && n < max_cyc) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, GRANT_VALID}, 32'd1);
    endtask

    initial begin
        bit seen;
        RESET = 1'b1; BTN_N = 2'b11;
        ARM = 1'b0; EARLY = 1'b0; LIVE = 1'b0; ACK = 1'b0;
        repeat (3) tick();
        chk("rst_valid",   {31'd0, GRANT_VALID}, 32'd0);
        chk("rst_id",      {31'd0, GRANT_ID},    32'd0);
        chk("rst_false",   {31'd0, GRANT_FALSE}, 32'd0);
        chk("rst_busy",    {31'd0, BUSY},        32'd0);
        chk("rst_pressed", {30'd0, PRESSED},     32'd0);
        RESET = 1'b0;
        tick();

        // 1: clean press by player 0, LIVE; grant lands exactly at cycle 7
        LIVE = 1'b1;
        arm();
        chk("t1_busy_armed", {31'd0, BUSY}, 32'd1);
        BTN_N = 2'b10;
        repeat (7) tick();
        chk("t1_valid_c6", {31'd0, GRANT_VALID}, 32'd0);
        tick();
        chk("t1_valid_c7", {31'd0, GRANT_VALID}, 32'd1);
        chk("t1_id",       {31'd0, GRANT_ID},    32'd0);
        chk("t1_false",    {31'd0, GRANT_FALSE}, 32'd0);
        chk("t1_pressed",  {30'd0, PRESSED},     32'd1);
        repeat (4) tick();
        chk("t1_hold_valid", {31'd0, GRANT_VALID}, 32'd1);
        chk("t1_hold_id",    {31'd0, GRANT_ID},    32'd0);
        ack();
        chk("t1_ack_valid", {31'd0, GRANT_VALID}, 32'd0);
        chk("t1_ack_busy",  {31'd0, BUSY},        32'd0);
        release_all();

        // 2: EARLY overrides LIVE -> false start by player 1
        EARLY = 1'b1;
        arm();
        BTN_N = 2'b01;
        wait_grant("t2_grant", 20);
        chk("t2_id",    {31'd0, GRANT_ID},    32'd1);
        chk("t2_false", {31'd0, GRANT_FALSE}, 32'd1);
        ack();
        EARLY = 1'b0;
        release_all();

        // 3: tie with pointer 0 -> player 0; next tie -> player 1
        arm();
        BTN_N = 2'b00;
        wait_grant("t3a_grant", 20);
        chk("t3a_id", {31'd0, GRANT_ID}, 32'd0);
        ack();
        release_all();
        arm();
        BTN_N = 2'b00;
        wait_grant("t3b_grant", 20);
        chk("t3b_id", {31'd0, GRANT_ID}, 32'd1);
        ack();
        release_all();

        // neither EARLY nor LIVE: press discarded, round stays open
        LIVE = 1'b0;
        arm();
        BTN_N = 2'b10;
        repeat (15) tick();
        chk("t_nolive_valid", {31'd0, GRANT_VALID}, 32'd0);
        chk("t_nolive_busy",  {31'd0, BUSY},        32'd1);
        ack();
        chk("t_ack_watch_busy", {31'd0, BUSY}, 32'd1);
        BTN_N = 2'b11;
        repeat (12) tick();
        LIVE = 1'b1;
        BTN_N = 2'b10;
        wait_grant("t_nolive_regrant", 20);
        chk("t_nolive_id", {31'd0, GRANT_ID}, 32'd0);
        ack();
        release_all();

        // 4: bounce on player 0, steady low from cycle 8 -> grant at cycle 15
        arm();
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            BTN_N = {1'b1, 1'((k / 2) % 2)};
            tick();
            seen |= GRANT_VALID;
        end
        repeat (5) tick();
        seen |= GRANT_VALID;
        chk("t4_no_early_grant", {31'd0, seen}, 32'd0);
        tick();
        chk("t4_valid_c15", {31'd0, GRANT_VALID}, 32'd1);
        chk("t4_id",        {31'd0, GRANT_ID},    32'd0);
        ack();
        release_all();

        // 5: held through ARM never qualifies; release and re-press does
        BTN_N = 2'b10;
        repeat (12) tick();
        chk("t5_pressed_idle", {30'd0, PRESSED}, 32'd1);
        arm();
        repeat (15) tick();
        chk("t5_held_valid", {31'd0, GRANT_VALID}, 32'd0);
        chk("t5_held_busy",  {31'd0, BUSY},        32'd1);
        BTN_N = 2'b11;
        repeat (12) tick();
        BTN_N = 2'b10;
        wait_grant("t5_grant", 20);
        chk("t5_id", {31'd0, GRANT_ID}, 32'd0);
        ARM = 1'b1;
        tick();
        ARM = 1'b0;
        chk("t5_arm_in_grant", {31'd0, GRANT_VALID}, 32'd1);
        ARM = 1'b1; ACK = 1'b1;
        tick();
        ARM = 1'b0; ACK = 1'b0;
        chk("t5_armack_busy", {31'd0, BUSY}, 32'd0);
        tick();
        chk("t5_arm_dropped", {31'd0, BUSY}, 32'd0);
        release_all();

        // 6: reset while granted (pointer is 1 here); tie afterwards -> 0
        arm();
        BTN_N = 2'b10;
        wait_grant("t6_grant", 20);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("t6_rst_valid",   {31'd0, GRANT_VALID}, 32'd0);
        chk("t6_rst_busy",    {31'd0, BUSY},        32'd0);
        chk("t6_rst_pressed", {30'd0, PRESSED},     32'd0);
        release_all();
        arm();
        BTN_N = 2'b00;
        wait_grant("t6_tie_grant", 20);
        chk("t6_ptr_reset_id", {31'd0, GRANT_ID}, 32'd0);
        ack();
        release_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
